// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the fetch alignment buffer:
//   INS_BITS / INS_BYTES : instruction width in bits / bytes (32-bit ISA)
//   PC_MAX_W             : widest PC an entry can hold
//   fetch_entry_t        : one buffered instruction {ins, pc}
//   slots_of()           : number of 32-bit slots in a fetch beat
// ---------------------------------------------------------------------------
package fetch_pkg;

  localparam int INS_BITS  = 32;
  localparam int INS_BYTES = 4;

  // Entries carry a PC of this fixed width; narrower PCs are zero-extended
  // on write and truncated again on read.
  localparam int PC_MAX_W  = 64;

  typedef struct packed {
    logic [INS_BITS-1:0] ins;
    logic [PC_MAX_W-1:0] pc;
  } fetch_entry_t;

  function automatic int slots_of(input int bus_width);
    return bus_width / INS_BITS;
  endfunction

endpackage

// File: rtl/fetch_slot_select.sv
// ---------------------------------------------------------------------------
// fetch_slot_select
// Combinational extraction of 32-bit slot k from a fetch beat, together with
// the PC of that slot (in_pc + INS_BYTES * k).
// Ports:
//   in_data [BUS_DATA_WIDTH] : fetch beat, slot 0 in the low 32 bits
//   in_pc   [PC_WIDTH]       : beat-aligned PC of slot 0
//   k       [SEL_W]          : slot index
//   ins     [32]             : slot k contents
//   pc      [PC_WIDTH]       : PC of slot k
// ---------------------------------------------------------------------------
module fetch_slot_select
  import fetch_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int PC_WIDTH       = 64,
  localparam int SEL_W         = $clog2(slots_of(BUS_DATA_WIDTH))
) (
  input  logic [BUS_DATA_WIDTH-1:0] in_data,
  input  logic [PC_WIDTH-1:0]       in_pc,
  input  logic [SEL_W-1:0]          k,
  output logic [INS_BITS-1:0]       ins,
  output logic [PC_WIDTH-1:0]       pc
);

  // {k, 5'b0} is k*32, the bit offset of the slot.
  assign ins = in_data[{k, 5'b00000} +: INS_BITS];
  assign pc  = in_pc + PC_WIDTH'(k) * PC_WIDTH'(INS_BYTES);

endmodule

// File: rtl/fetch_align_buffer.sv
// ---------------------------------------------------------------------------
// fetch_align_buffer
// Splits wide fetch beats into 32-bit instructions, queues each with its PC
// in a circular buffer and hands them to decode one per cycle.
//
// Optional feature macro: FETCH_BUF_BYPASS_EN
//   When defined, an empty buffer forwards slot in_start_slot of an incoming
//   beat to out_* combinationally (zero-cycle redirect latency); if decode
//   takes it that cycle, the slot is not stored.
//
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   in_valid/in_ready : fetch beat handshake; in_ready means room for a
//                       whole beat (SLOTS entries)
//   in_data, in_pc    : beat and PC of its slot 0
//   in_start_slot     : first valid slot of the beat (lower slots dropped)
//   flush             : discard everything buffered and in flight
//   out_valid/out_ready, out_ins, out_pc : instruction to decode
//   count             : occupied entries
//
// Handshake semantics (both sides): a transfer happens on a rising edge
// where valid && ready. in_ready never depends on in_valid, and out_valid
// never depends on out_ready. While valid is high and ready low, the
// payload on out_* holds stable.
// ---------------------------------------------------------------------------
module fetch_align_buffer
  import fetch_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int DEPTH          = 8,
  parameter int PC_WIDTH       = 64,
  localparam int SLOTS         = slots_of(BUS_DATA_WIDTH),
  localparam int SEL_W         = $clog2(SLOTS),
  localparam int PTR_W         = $clog2(DEPTH),
  localparam int CNT_W         = PTR_W + 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [BUS_DATA_WIDTH-1:0] in_data,
  input  logic [PC_WIDTH-1:0]       in_pc,
  input  logic [SEL_W-1:0]          in_start_slot,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [INS_BITS-1:0]       out_ins,
  output logic [PC_WIDTH-1:0]       out_pc,
  output logic [CNT_W-1:0]          count
);

  logic [PTR_W-1:0] rd_ptr, rd_ptr_n;
  logic [PTR_W-1:0] wr_ptr, wr_ptr_n;
  logic [CNT_W-1:0] count_q, count_n;

  fetch_entry_t mem [DEPTH];
  fetch_entry_t last_q, last_n;     // last delivered entry, shown while empty
  fetch_entry_t slot_ent [SLOTS];
  fetch_entry_t head_ent, byp_ent, out_ent;

  logic [PTR_W-1:0] wr_idx [SLOTS];
  logic [SLOTS-1:0] wr_en;
  logic [CNT_W-1:0] n_wr;

  logic accept, pop_buf, byp, byp_pop;

  // -------------------------------------------------------------------------
  // Slot extraction, shared by the write path and the bypass path
  // -------------------------------------------------------------------------
  for (genvar g = 0; g < SLOTS; g++) begin : g_slot
    logic [INS_BITS-1:0] s_ins;
    logic [PC_WIDTH-1:0] s_pc;

    fetch_slot_select #(
      .BUS_DATA_WIDTH (BUS_DATA_WIDTH),
      .PC_WIDTH       (PC_WIDTH)
    ) u_sel (
      .in_data (in_data),
      .in_pc   (in_pc),
      .k       (SEL_W'(g)),
      .ins     (s_ins),
      .pc      (s_pc)
    );

    assign slot_ent[g] = '{ins: s_ins, pc: PC_MAX_W'(s_pc)};
  end

  assign head_ent = mem[rd_ptr];
  assign byp_ent  = slot_ent[in_start_slot];

  // -------------------------------------------------------------------------
  // Handshake terms
  // -------------------------------------------------------------------------
  // Space check uses the registered count only: a pop in the same cycle does
  // not make room, which keeps in_ready off any out_ready path.
  assign in_ready = rst_n && !flush &&
                    ((CNT_W'(DEPTH) - count_q) >= CNT_W'(SLOTS));

`ifdef FETCH_BUF_BYPASS_EN
  assign byp = rst_n && !flush && in_valid && (count_q == '0);
`else
  assign byp = 1'b0;
`endif

  assign out_valid = rst_n && !flush && ((count_q != '0) || byp);
  assign accept    = in_valid && in_ready;
  assign byp_pop   = byp && out_ready;
  // A bypassed instruction never touches storage, so it is not a buffer pop.
  assign pop_buf   = out_valid && out_ready && !byp;

  // -------------------------------------------------------------------------
  // Write plan: slots start..SLOTS-1 land contiguously from wr_ptr, wrapping
  // modulo DEPTH. A slot consumed by the bypass is skipped and the later
  // slots close the gap.
  // -------------------------------------------------------------------------
  always_comb begin
    n_wr  = '0;
    wr_en = '0;
    for (int i = 0; i < SLOTS; i++) begin
      wr_idx[i] = wr_ptr + PTR_W'(i) - PTR_W'(in_start_slot) - PTR_W'(byp_pop);
      if (accept && (i >= int'(in_start_slot)) &&
          !(byp_pop && (i == int'(in_start_slot)))) begin
        wr_en[i] = 1'b1;
        n_wr     = n_wr + CNT_W'(1);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Pointer / count next state
  // -------------------------------------------------------------------------
  always_comb begin
    rd_ptr_n = rd_ptr;
    wr_ptr_n = wr_ptr;
    count_n  = count_q;
    last_n   = last_q;
    if (flush) begin
      rd_ptr_n = '0;
      wr_ptr_n = '0;
      count_n  = '0;
    end else begin
      wr_ptr_n = wr_ptr + PTR_W'(n_wr);
      rd_ptr_n = rd_ptr + PTR_W'(pop_buf);
      count_n  = count_q + n_wr - CNT_W'(pop_buf);
      if (pop_buf) begin
        last_n = head_ent;
      end else if (byp_pop) begin
        last_n = byp_ent;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      last_q  <= '0;
    end else begin
      rd_ptr  <= rd_ptr_n;
      wr_ptr  <= wr_ptr_n;
      count_q <= count_n;
      last_q  <= last_n;
    end
  end

  // Storage has no reset: an entry is only read once count covers it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < SLOTS; i++) begin
      if (wr_en[i]) begin
        mem[wr_idx[i]] <= slot_ent[i];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Output mux: bypass slot, else buffer head, else the last delivered entry
  // -------------------------------------------------------------------------
  always_comb begin
    out_ent = last_q;
    if (byp) begin
      out_ent = byp_ent;
    end else if (count_q != '0) begin
      out_ent = head_ent;
    end
  end

  assign out_ins = out_ent.ins;
  assign out_pc  = PC_WIDTH'(out_ent.pc);
  assign count   = count_q;

  // Start slot can only be out of range when SLOTS is not a power of two.
  if ((1 << SEL_W) != SLOTS) begin : g_start_chk
    always @(posedge clk) begin
      if (rst_n && accept) begin
        assert (int'(in_start_slot) < SLOTS);
      end
    end
  end

endmodule

// File: tb/tb_fetch_align_buffer.sv
// ---------------------------------------------------------------------------
// tb_fetch_align_buffer
// Directed bench for fetch_align_buffer: a 64-bit/8-entry instance for the
// main scenarios and a 128-bit instance for wide-beat redirects.
// ---------------------------------------------------------------------------
module tb_fetch_align_buffer;

`ifdef FETCH_BUF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b1;

  // 64-bit instance
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [63:0] in_data, in_pc, out_pc;
  logic [0:0]  in_start_slot;
  logic [31:0] out_ins;
  logic [3:0]  count;

  // 128-bit instance
  logic         w_in_valid, w_in_ready, w_flush, w_out_valid, w_out_ready;
  logic [127:0] w_in_data;
  logic [63:0]  w_in_pc, w_out_pc;
  logic [1:0]   w_in_start_slot;
  logic [31:0]  w_out_ins;
  logic [3:0]   w_count;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_align_buffer #(.BUS_DATA_WIDTH(64), .DEPTH(8), .PC_WIDTH(64)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_pc(in_pc), .in_start_slot(in_start_slot),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_ins(out_ins), .out_pc(out_pc), .count(count)
  );

  fetch_align_buffer #(.BUS_DATA_WIDTH(128), .DEPTH(8), .PC_WIDTH(64)) dut_w (
    .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_data(w_in_data), .in_pc(w_in_pc), .in_start_slot(w_in_start_slot),
    .flush(w_flush), .out_valid(w_out_valid), .out_ready(w_out_ready),
    .out_ins(w_out_ins), .out_pc(w_out_pc), .count(w_count)
  );

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_data = '0; in_pc = '0; in_start_slot = '0;
    flush = 0; out_ready = 0;
    w_in_valid = 0; w_in_data = '0; w_in_pc = '0; w_in_start_slot = '0;
    w_flush = 0; w_out_ready = 0;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset();
    idle_inputs();
    #2 rst_n = 0;
    repeat (2) @(posedge clk);
    #2;
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %0b want 0", in_ready); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %0b want 0", out_valid); end
    n_tests++; if (count !== 4'd0) begin n_fail++; $display("FAIL rst_count: got %0d want 0", count); end
    n_tests++; if (out_ins !== 32'd0) begin n_fail++; $display("FAIL rst_out_ins: got %h want 0", out_ins); end
    n_tests++; if (out_pc !== 64'd0) begin n_fail++; $display("FAIL rst_out_pc: got %h want 0", out_pc); end
    n_tests++; if (w_in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_w_in_ready: got %0b want 0", w_in_ready); end
    rst_n = 1;
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_in_ready: got %0b want 1", in_ready); end
    tick();
  endtask

  // -------------------------------------------------------------------------
  task automatic test_basic();
    in_valid = 1; in_data = 64'h22222222_11111111; in_pc = 64'h1000;
    in_start_slot = 1'b0; out_ready = !BYP;
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_in_ready: got %0b want 1", in_ready); end
    n_tests++; if (out_valid !== BYP) begin n_fail++; $display("FAIL basic_same_cycle_valid: got %0b want %0b", out_valid, BYP); end
    tick();
    in_valid = 0; out_ready = 1;
    #1;
    n_tests++; if (count !== 4'd2) begin n_fail++; $display("FAIL basic_count: got %0d want 2", count); end
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid0: got %0b want 1", out_valid); end
    n_tests++; if (out_ins !== 32'h11111111) begin n_fail++; $display("FAIL basic_ins0: got %h want 11111111", out_ins); end
    n_tests++; if (out_pc !== 64'h1000) begin n_fail++; $display("FAIL basic_pc0: got %h want 1000", out_pc); end
    tick();
    n_tests++; if (count !== 4'd1) begin n_fail++; $display("FAIL basic_count1: got %0d want 1", count); end
    n_tests++; if (out_ins !== 32'h22222222) begin n_fail++; $display("FAIL basic_ins1: got %h want 22222222", out_ins); end
    n_tests++; if (out_pc !== 64'h1004) begin n_fail++; $display("FAIL basic_pc1: got %h want 1004", out_pc); end
    tick();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_empty_valid: got %0b want 0", out_valid); end
    n_tests++; if (count !== 4'd0) begin n_fail++; $display("FAIL basic_empty_count: got %0d want 0", count); end
    n_tests++; if (out_ins !== 32'h22222222) begin n_fail++; $display("FAIL basic_empty_hold: got %h want 22222222", out_ins); end
    out_ready = 0;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_redirect();
    in_valid = 1; in_data = 64'h0000BBBB_0000AAAA; in_pc = 64'h2000;
    in_start_slot = 1'b1; out_ready = 0;
    #1;
    n_tests++; if (out_valid !== BYP) begin n_fail++; $display("FAIL redir_same_cycle_valid: got %0b want %0b", out_valid, BYP); end
    tick();
    in_valid = 0;
    #1;
    n_tests++; if (count !== 4'd1) begin n_fail++; $display("FAIL redir_count: got %0d want 1", count); end
    n_tests++; if (out_ins !== 32'h0000BBBB) begin n_fail++; $display("FAIL redir_ins: got %h want 0000bbbb", out_ins); end
    n_tests++; if (out_pc !== 64'h2004) begin n_fail++; $display("FAIL redir_pc: got %h want 2004", out_pc); end
    out_ready = 1;
    tick();
    n_tests++; if (count !== 4'd0) begin n_fail++; $display("FAIL redir_drain_count: got %0d want 0", count); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL redir_drain_valid: got %0b want 0", out_valid); end
    out_ready = 0;
  endtask

  // -------------------------------------------------------------------------
  // Fill to full while stalled, then drain across the pointer wrap while a
  // fifth beat waits for space.
  task automatic test_fill_wrap();
    logic [31:0] lo;
    int exp_cnt;
    bit pending, acc;
    out_ready = 0; in_start_slot = 1'b0;
    for (int b = 0; b < 5; b++) begin
      lo = 32'hF000_0000 + 32'(2 * b);
      in_valid = 1; in_data = {lo + 32'd1, lo}; in_pc = 64'h4000 + 64'(8 * b);
      #1;
      if (b < 4) begin
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL fill_in_ready_b%0d: got %0b want 1", b, in_ready); end
        if (b > 0) begin
          n_tests++; if (out_ins !== 32'hF0000000) begin n_fail++; $display("FAIL fill_stall_hold_b%0d: got %h want f0000000", b, out_ins); end
        end
        tick();
      end
    end
    n_tests++; if (count !== 4'd8) begin n_fail++; $display("FAIL fill_full_count: got %0d want 8", count); end
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_full_in_ready: got %0b want 0", in_ready); end
    out_ready = 1;
    #1;
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_no_credit: got %0b want 0", in_ready); end
    exp_cnt = 8; pending = 1;
    for (int j = 0; j < 10; j++) begin
      n_tests++; if (count !== 4'(exp_cnt)) begin n_fail++; $display("FAIL drain_count_%0d: got %0d want %0d", j, count, exp_cnt); end
      n_tests++; if (in_ready !== (exp_cnt <= 6)) begin n_fail++; $display("FAIL drain_in_ready_%0d: got %0b want %0b", j, in_ready, exp_cnt <= 6); end
      n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL drain_valid_%0d: got %0b want 1", j, out_valid); end
      n_tests++; if (out_ins !== 32'hF000_0000 + 32'(j)) begin n_fail++; $display("FAIL drain_ins_%0d: got %h want %h", j, out_ins, 32'hF000_0000 + 32'(j)); end
      n_tests++; if (out_pc !== 64'h4000 + 64'(4 * j)) begin n_fail++; $display("FAIL drain_pc_%0d: got %h want %h", j, out_pc, 64'h4000 + 64'(4 * j)); end
      acc = pending && (exp_cnt <= 6);
      tick();
      if (acc) begin
        pending = 0; in_valid = 0;
      end
      exp_cnt = exp_cnt - 1 + (acc ? 2 : 0);
      #1;
    end
    n_tests++; if (count !== 4'd0) begin n_fail++; $display("FAIL drain_final_count: got %0d want 0", count); end
    out_ready = 0;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_flush();
    out_ready = 0;
    in_valid = 1; in_start_slot = 1'b0; in_data = {32'hF1000001, 32'hF1000000}; in_pc = 64'h5000;
    tick();
    in_data = {32'hF1000003, 32'hF1000002}; in_pc = 64'h5008;
    tick();
    in_start_slot = 1'b1; in_data = {32'hF1000005, 32'hF1000004}; in_pc = 64'h5010;
    tick();
    in_start_slot = 1'b0; in_data = {32'hDEAD0001, 32'hDEAD0000}; in_pc = 64'h6000;
    #1;
    n_tests++; if (count !== 4'd5) begin n_fail++; $display("FAIL flush_pre_count: got %0d want 5", count); end
    flush = 1; out_ready = 1;
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid: got %0b want 0", out_valid); end
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready: got %0b want 0", in_ready); end
    tick();
    flush = 0; in_valid = 0; out_ready = 0;
    #1;
    n_tests++; if (count !== 4'd0) begin n_fail++; $display("FAIL flush_post_count: got %0d want 0", count); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_post_valid: got %0b want 0", out_valid); end
    in_valid = 1; in_data = {32'h30000001, 32'h30000000}; in_pc = 64'h3000;
    tick();
    in_valid = 0;
    #1;
    n_tests++; if (count !== 4'd2) begin n_fail++; $display("FAIL flush_next_count: got %0d want 2", count); end
    n_tests++; if (out_ins !== 32'h30000000) begin n_fail++; $display("FAIL flush_next_ins: got %h want 30000000", out_ins); end
    n_tests++; if (out_pc !== 64'h3000) begin n_fail++; $display("FAIL flush_next_pc: got %h want 3000", out_pc); end
    out_ready = 1;
    tick();
    n_tests++; if (out_ins !== 32'h30000001) begin n_fail++; $display("FAIL flush_next_ins1: got %h want 30000001", out_ins); end
    n_tests++; if (out_pc !== 64'h3004) begin n_fail++; $display("FAIL flush_next_pc1: got %h want 3004", out_pc); end
    tick();
    n_tests++; if (count !== 4'd0) begin n_fail++; $display("FAIL flush_next_drain: got %0d want 0", count); end
    out_ready = 0;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_async_reset();
    out_ready = 0;
    in_valid = 1; in_start_slot = 1'b0; in_data = {32'hA0000001, 32'hA0000000}; in_pc = 64'h7000;
    tick();
    in_start_slot = 1'b1; in_data = {32'hA0000003, 32'hA0000002}; in_pc = 64'h7008;
    tick();
    in_valid = 0;
    #1;
    n_tests++; if (count !== 4'd3) begin n_fail++; $display("FAIL arst_pre_count: got %0d want 3", count); end
    #2 rst_n = 0;
    #1;
    n_tests++; if (count !== 4'd0) begin n_fail++; $display("FAIL arst_count: got %0d want 0", count); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_valid: got %0b want 0", out_valid); end
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL arst_in_ready: got %0b want 0", in_ready); end
    n_tests++; if (out_ins !== 32'd0) begin n_fail++; $display("FAIL arst_out_ins: got %h want 0", out_ins); end
    #1 rst_n = 1;
    tick();
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL arst_release_in_ready: got %0b want 1", in_ready); end
    n_tests++; if (count !== 4'd0) begin n_fail++; $display("FAIL arst_release_count: got %0d want 0", count); end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_wide();
    logic [31:0] exp_ins [3];
    exp_ins = '{32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3};
    w_out_ready = 1; w_in_valid = 1;
    w_in_data = 128'h44444444_33333333_22222222_11111111;
    w_in_pc = 64'h8000; w_in_start_slot = 2'd3;
    #1;
    n_tests++; if (w_in_ready !== 1'b1) begin n_fail++; $display("FAIL wide_in_ready: got %0b want 1", w_in_ready); end
`ifdef FETCH_BUF_BYPASS_EN
    n_tests++; if (w_out_valid !== 1'b1) begin n_fail++; $display("FAIL wide_byp_valid: got %0b want 1", w_out_valid); end
    n_tests++; if (w_out_ins !== 32'h44444444) begin n_fail++; $display("FAIL wide_byp_ins: got %h want 44444444", w_out_ins); end
    n_tests++; if (w_out_pc !== 64'h800C) begin n_fail++; $display("FAIL wide_byp_pc: got %h want 800c", w_out_pc); end
    tick();
    w_in_valid = 0;
    #1;
    n_tests++; if (w_count !== 4'd0) begin n_fail++; $display("FAIL wide_byp_count: got %0d want 0", w_count); end
    n_tests++; if (w_out_valid !== 1'b0) begin n_fail++; $display("FAIL wide_byp_after_valid: got %0b want 0", w_out_valid); end
    n_tests++; if (w_out_ins !== 32'h44444444) begin n_fail++; $display("FAIL wide_byp_hold: got %h want 44444444", w_out_ins); end
`else
    n_tests++; if (w_out_valid !== 1'b0) begin n_fail++; $display("FAIL wide_no_byp_valid: got %0b want 0", w_out_valid); end
    tick();
    w_in_valid = 0;
    #1;
    n_tests++; if (w_count !== 4'd1) begin n_fail++; $display("FAIL wide_count: got %0d want 1", w_count); end
    n_tests++; if (w_out_valid !== 1'b1) begin n_fail++; $display("FAIL wide_valid: got %0b want 1", w_out_valid); end
    n_tests++; if (w_out_ins !== 32'h44444444) begin n_fail++; $display("FAIL wide_ins: got %h want 44444444", w_out_ins); end
    n_tests++; if (w_out_pc !== 64'h800C) begin n_fail++; $display("FAIL wide_pc: got %h want 800c", w_out_pc); end
    tick();
    n_tests++; if (w_count !== 4'd0) begin n_fail++; $display("FAIL wide_drain: got %0d want 0", w_count); end
`endif
    w_out_ready = 0; w_in_valid = 1; w_in_start_slot = 2'd1; w_in_pc = 64'h9000;
    w_in_data = 128'hD3D3D3D3_C2C2C2C2_B1B1B1B1_A0A0A0A0;
    tick();
    w_in_valid = 0;
    #1;
    n_tests++; if (w_count !== 4'd3) begin n_fail++; $display("FAIL wide3_count: got %0d want 3", w_count); end
    w_out_ready = 1;
    #1;
    for (int j = 0; j < 3; j++) begin
      n_tests++; if (w_out_ins !== exp_ins[j]) begin n_fail++; $display("FAIL wide3_ins_%0d: got %h want %h", j, w_out_ins, exp_ins[j]); end
      n_tests++; if (w_out_pc !== 64'h9004 + 64'(4 * j)) begin n_fail++; $display("FAIL wide3_pc_%0d: got %h want %h", j, w_out_pc, 64'h9004 + 64'(4 * j)); end
      tick();
    end
    n_tests++; if (w_count !== 4'd0) begin n_fail++; $display("FAIL wide3_drain: got %0d want 0", w_count); end
    w_out_ready = 0;
  endtask

  // -------------------------------------------------------------------------
  initial begin
    test_reset();
    test_basic();
    test_redirect();
    test_fill_wrap();
    test_flush();
    test_async_reset();
    test_wide();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_align_buffer.md
Name: fetch_align_buffer

Overview:
Parametrised successor to the fixed 64-bit/2-slot fetch splitter. It accepts wide instruction-bus beats, which may start at any 32-bit slot after a branch redirect, and splits them into 32-bit instructions. Each instruction is queued with its PC in a circular buffer and delivered to decode one per cycle over a valid/ready handshake. It sits between the bus interface and decode1, and supports pipeline flush and decode stall.

Parameters:
BUS_DATA_WIDTH, 64, fetch beat width in bits; must be a multiple of 32, range 64..256.
DEPTH, 8, instruction entries in the buffer; power of two, at least BUS_DATA_WIDTH/32.
PC_WIDTH, 64, PC width in bits.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  fetch beat present.
in_ready  output  1  buffer can accept a full beat this cycle.
in_data  input  BUS_DATA_WIDTH  beat; slot i = in_data[32*i+31:32*i]; slot 0 is oldest.
in_pc  input  PC_WIDTH  beat-aligned address of slot 0.
in_start_slot  input  $clog2(SLOTS)  first valid slot; lower slots are discarded (branch target mid-beat).
flush  input  1  discard all buffered and in-flight instructions.
out_valid  output  1  out_ins/out_pc valid.
out_ready  input  1  decode accepts; low means stall.
out_ins  output  32  instruction at buffer head.
out_pc  output  PC_WIDTH  PC of out_ins.
count  output  $clog2(DEPTH)+1  occupied entries.

Behaviour:
- SLOTS = BUS_DATA_WIDTH/32. An entry is {ins[31:0], pc[PC_WIDTH-1:0]}.
- Reset (rst_n low, asynchronous): read and write pointers = 0, count = 0, out_valid = 0, out_ins = 0, out_pc = 0. in_ready is 0 while reset is asserted and 1 on the first cycle after release.
- in_ready = !flush && (DEPTH - count >= SLOTS). It is combinational from registered count and flush, and must not depend on in_valid.
- Write acceptance: a beat is accepted when in_valid && in_ready.
  - Slots in_start_slot..SLOTS-1 are written in ascending order at write pointer onward.
  - The PC of slot i is in_pc + 4*i.
  - An in_start_slot >= SLOTS is illegal; assertion only.
- Read: a handshake occurs when out_valid && out_ready. The head advances by one entry per handshake.
- out_valid = (count != 0) && !flush.
- Simultaneous accept and pop in one cycle: count_next = count + written - 1.
- Pointers are $clog2(DEPTH) bits and wrap naturally modulo DEPTH. Slot writes that cross the wrap boundary must land contiguously.
- Latency: without bypass, an instruction is visible on out_* on the cycle after its beat is accepted. First-in-first-out order is preserved across beats.
- Flush:
  - Same cycle: in_ready = 0 and out_valid = 0. No write or pop takes effect.
  - Next edge: pointers and count return to 0.
  - A flush together with in_valid drops the beat.
  - A flush during reset is ignored.
- Stall: while out_ready = 0, out_ins and out_pc must hold stable.
- Full: when count > DEPTH - SLOTS, in_ready = 0 even if out_ready = 1 in the same cycle; there is no combinational credit for a concurrent pop.
- Empty: out_valid = 0, and out_ins/out_pc hold their last value.

Optional Feature:
FETCH_BUF_BYPASS_EN
- Defined: when count == 0, !flush and in_valid, out_valid is driven combinationally. out_ins = slot in_start_slot and out_pc = in_pc + 4*in_start_slot.
  - If out_ready is also high, that slot is consumed and not stored, and only the remaining slots are written.
  - Result: zero-cycle latency after a redirect.
- Undefined: the bypass path is absent, and the one-cycle minimum latency applies.

Decomposition:
- Package fetch_pkg holds:
  - the localparam SLOTS derivation function;
  - the typedef fetch_entry_t {ins, pc};
  - the constant INS_BYTES = 4.
- One sub-module, fetch_slot_select: combinational extraction of slot k and its PC from in_data/in_pc, shared by the write path and the bypass path.
- Storage and the pointer/count FSM stay in the top module.

Test Plan:
1. Reset, then one beat (64-bit) in_data=0x22222222_11111111, in_pc=0x1000, start=0, out_ready=1 -> 0x11111111/pc 0x1000, then 0x22222222/pc 0x1004, then out_valid=0.
2. Redirect: in_pc=0x2000, start=1, data=0xBBBB_AAAA -> only 0xBBBB emitted, pc=0x2004; count peaks at 1.
3. Fill with out_ready=0, DEPTH=8, beats of 2 -> in_ready drops after 4 beats (count=8); with out_ready=1, no new beat is accepted until count<=6; order and PCs are correct across pointer wrap.
4. Flush at count=5 with in_valid=1 -> out_valid=0 that cycle, count=0 the next cycle, beat dropped; the next beat at pc 0x3000 is emitted first.
5. rst_n asserted mid-stream (count=3), asynchronous mid-cycle -> out_valid=0 and count=0 immediately, before the next clock edge.
6. BUS_DATA_WIDTH=128, start=3, with FETCH_BUF_BYPASS_EN defined on an empty buffer -> out_valid in the same cycle with slot 3 at pc in_pc+12, and count stays 0.
